// File: rtl/npc_pkg.sv
`default_nettype none
//==============================================================================
// Module : npc_pkg
// Brief  : Shared register-index/data types and sizing helpers for writeback.
// Rev    : 1.0
//==============================================================================
package npc_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 5;
    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_MAX_PENDING = 4;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] xlen_t;

    localparam reg_idx_t REG_ZERO = '0;

    // Counter width able to hold 0..max_pending inclusive.
    function automatic int pending_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_commit_unit_if.sv
`default_nettype none
//==============================================================================
// Module : wb_commit_unit_if
// Brief  : Issue / result / register-file bundle between the pipeline and the commit unit.
// Rev    : 1.0
//==============================================================================
interface wb_commit_unit_if
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int MAX_PENDING = DEFAULT_MAX_PENDING
);
    localparam int PEND_WIDTH = pending_width(MAX_PENDING);

    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_rd;
    logic                  iss_ready;

    logic [ADDR_WIDTH-1:0] raddr1;
    logic [ADDR_WIDTH-1:0] raddr2;
    logic                  hz1;
    logic                  hz2;

    logic                  exu_valid;
    logic [ADDR_WIDTH-1:0] exu_rd;
    logic [DATA_WIDTH-1:0] exu_data;
    logic                  exu_ready;

    logic                  lsu_valid;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    logic [PEND_WIDTH-1:0] pending;
    logic                  err;

    modport master (
        output iss_valid, iss_rd, raddr1, raddr2,
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  iss_ready, hz1, hz2, exu_ready,
        input  rf_wen, rf_waddr, rf_wdata, pending, err
    );

    modport slave (
        input  iss_valid, iss_rd, raddr1, raddr2,
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output iss_ready, hz1, hz2, exu_ready,
        output rf_wen, rf_waddr, rf_wdata, pending, err
    );

endinterface
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
//==============================================================================
// Module : wb_scoreboard
// Brief  : Per-register busy bits, in-flight counter, hazard lookups and sticky error.
// Rev    : 1.0
//==============================================================================
module wb_scoreboard
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int MAX_PENDING = DEFAULT_MAX_PENDING,
    parameter int PEND_WIDTH  = pending_width(MAX_PENDING)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  hz1,
    output logic                  hz2,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  err
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_next;
    logic [PEND_WIDTH-1:0] r_pending;
    logic [PEND_WIDTH-1:0] w_pending_next;
    logic                  r_err;

    logic w_iss_zero;
    logic w_room;
    logic w_set;
    logic w_clr_hit;
    logic w_clr_miss;

    always_comb begin
        w_iss_zero = (iss_rd == '0);
        w_room     = (r_pending < PEND_WIDTH'(MAX_PENDING));
        // x0 bypasses both the WAW and the capacity stall.
        iss_ready  = w_iss_zero || (!r_busy[iss_rd] && w_room);
        w_set      = iss_valid && iss_ready && !w_iss_zero;
        w_clr_hit  = clr_en && r_busy[clr_idx];
        w_clr_miss = clr_en && !r_busy[clr_idx];

        // Clear is applied after set so that it wins on a shared index.
        w_busy_next = r_busy;
        if (w_set) begin
            w_busy_next[iss_rd] = 1'b1;
        end
        if (w_clr_hit) begin
            w_busy_next[clr_idx] = 1'b0;
        end

        w_pending_next = r_pending;
        if (w_set && !w_clr_hit) begin
            w_pending_next = r_pending + PEND_WIDTH'(1);
        end else if (!w_set && w_clr_hit) begin
            w_pending_next = r_pending - PEND_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy    <= '0;
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            r_busy    <= w_busy_next;
            r_pending <= w_pending_next;
            if (w_clr_miss) begin
                r_err <= 1'b1;
            end
        end
    end

    assign hz1     = r_busy[raddr1] && (raddr1 != '0);
    assign hz2     = r_busy[raddr2] && (raddr2 != '0);
    assign pending = r_pending;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: rtl/wb_commit_unit.sv
`default_nettype none
//==============================================================================
// Module : wb_commit_unit
// Brief  : LSU-priority result arbitration into one registered RF write port, plus busy scoreboard.
// Rev    : 1.0
//==============================================================================
module wb_commit_unit
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int MAX_PENDING = DEFAULT_MAX_PENDING
) (
    input  logic              clk,
    input  logic              rst,
    wb_commit_unit_if.slave   bus
);

    localparam int PEND_WIDTH = pending_width(MAX_PENDING);

    logic                  w_acc_valid;
    logic [ADDR_WIDTH-1:0] w_acc_rd;
    logic [DATA_WIDTH-1:0] w_acc_data;

    logic                  r_rf_wen;
    logic [ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0] r_rf_wdata;

    logic                  w_iss_ready;
    logic                  w_hz1;
    logic                  w_hz2;
    logic [PEND_WIDTH-1:0] w_pending;
    logic                  w_err;

    // Loads cannot be back-pressured, so the EXU only wins when the LSU is idle.
    always_comb begin
        w_acc_valid = bus.lsu_valid || bus.exu_valid;
        w_acc_rd    = bus.exu_rd;
        w_acc_data  = bus.exu_data;
        if (bus.lsu_valid) begin
            w_acc_rd   = bus.lsu_rd;
            w_acc_data = bus.lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if (w_acc_valid) begin
            r_rf_wen   <= (w_acc_rd != '0);
            r_rf_waddr <= w_acc_rd;
            r_rf_wdata <= w_acc_data;
        end else begin
            r_rf_wen   <= 1'b0;
        end
    end

    wb_scoreboard #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MAX_PENDING (MAX_PENDING),
        .PEND_WIDTH  (PEND_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .iss_ready (w_iss_ready),
        .clr_en    (r_rf_wen),
        .clr_idx   (r_rf_waddr),
        .raddr1    (bus.raddr1),
        .raddr2    (bus.raddr2),
        .hz1       (w_hz1),
        .hz2       (w_hz2),
        .pending   (w_pending),
        .err       (w_err)
    );

    assign bus.exu_ready = !bus.lsu_valid;
    assign bus.iss_ready = w_iss_ready;
    assign bus.hz1       = w_hz1;
    assign bus.hz2       = w_hz2;
    assign bus.pending   = w_pending;
    assign bus.err       = w_err;
    assign bus.rf_wen    = r_rf_wen;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;

endmodule
`default_nettype wire
